// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//   Command-driven operand sequencer for the Kalman-filter arithmetic unit.
//   Keeps a register file of S9.14 sign-magnitude words, decodes ADD/SUB/MUL/INV
//   commands into ALU operand/control settings, waits for the ALU result (with a
//   cont handshake and timeout for INV) and writes the result back.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; accepted on valid & ready
//   cmd_op/dst/a/b           opcode (00 ADD, 01 SUB, 10 MUL, 11 INV) and registers
//   ld_en/ld_addr/ld_data    host write port into the register file
//   rd_addr/rd_data          host combinational read port
//   alu_r/alu_s              registered ALU operands
//   alu_ctl_f/alu_ctl_e      registered ALU function controls
//   alu_inv_rst              one-cycle start pulse for the ALU inverse unit
//   alu_result/alu_cont      ALU result and continue/ready
//   done                     one-cycle pulse after a writeback
//   err                      sticky INV error (timeout or inverse of zero)
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int W           = 24,
   parameter int NREG        = 16,
   parameter int AW          = 4,
   parameter int INV_TIMEOUT = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW-1:0] cmd_a,
   input  logic [AW-1:0] cmd_b,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [W-1:0]  ld_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data,
   output logic [W-1:0]  alu_r,
   output logic [W-1:0]  alu_s,
   output logic          alu_ctl_f,
   output logic          alu_ctl_e,
   output logic          alu_inv_rst,
   input  logic [W-1:0]  alu_result,
   input  logic          alu_cont,
   output logic          done,
   output logic          err
);

   localparam int TW = $clog2(INV_TIMEOUT + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_INV = 2'b11;

   localparam logic [W-2:0] MAG_ONES = {(W-1){1'b1}};
   localparam logic [W-2:0] MAG_ZERO = {(W-1){1'b0}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [AW-1:0]   dst_q, dst_d;
   logic [AW-1:0]   a_q, a_d;
   logic [AW-1:0]   b_q, b_d;
   logic [W-1:0]    res_q, res_d;
   logic            a_sign_q, a_sign_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [W-1:0]    alu_r_q, alu_r_d;
   logic [W-1:0]    alu_s_q, alu_s_d;
   logic            alu_f_q, alu_f_d;
   logic            alu_e_q, alu_e_d;
   logic            alu_inv_rst_q, alu_inv_rst_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [W-1:0]    regfile_q [NREG];
   logic [W-1:0]    regfile_d [NREG];

   logic [W-1:0]    opa_s;
   logic [W-1:0]    opb_s;
   logic            wb_en_s;

   // Operands are read from the current (pre-edge) register contents.
   assign opa_s     = regfile_q[a_q];
   assign opb_s     = regfile_q[b_q];
   assign wb_en_s   = (state_q == S_WB);

   // WB is the last cycle of an operation; a new command may be accepted
   // alongside the writeback so back-to-back commands issue every 3 cycles.
   assign cmd_ready = (state_q == S_IDLE) || (state_q == S_WB);

   assign rd_data     = regfile_q[rd_addr];
   assign alu_r       = alu_r_q;
   assign alu_s       = alu_s_q;
   assign alu_ctl_f   = alu_f_q;
   assign alu_ctl_e   = alu_e_q;
   assign alu_inv_rst = alu_inv_rst_q;
   assign done        = done_q;
   assign err         = err_q;

   // Next-state, operand issue, result capture and register-file update.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      dst_d         = dst_q;
      a_d           = a_q;
      b_d           = b_q;
      res_d         = res_q;
      a_sign_d      = a_sign_q;
      timer_d       = timer_q;
      alu_r_d       = alu_r_q;
      alu_s_d       = alu_s_q;
      alu_f_d       = alu_f_q;
      alu_e_d       = alu_e_q;
      alu_inv_rst_d = 1'b0;
      done_d        = wb_en_s;
      err_d         = err_q;

      case (state_q)
         S_IDLE, S_WB: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               dst_d   = cmd_dst;
               a_d     = cmd_a;
               b_d     = cmd_b;
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            timer_d  = {TW{1'b0}};
            a_sign_d = opa_s[W-1];
            state_d  = S_WAIT;
            case (op_q)
               OP_ADD: begin
                  alu_r_d = opa_s;
                  alu_s_d = opb_s;
                  alu_f_d = 1'b0;
                  alu_e_d = 1'b0;
               end
               OP_SUB: begin
                  // Subtraction is addition with the sign bit of B flipped.
                  alu_r_d = opa_s;
                  alu_s_d = {~opb_s[W-1], opb_s[W-2:0]};
                  alu_f_d = 1'b0;
                  alu_e_d = 1'b0;
               end
               OP_MUL: begin
                  alu_r_d = opa_s;
                  alu_s_d = opb_s;
                  alu_f_d = 1'b1;
                  alu_e_d = 1'b0;
               end
               OP_INV: begin
                  if (opa_s[W-2:0] == MAG_ZERO) begin
                     // Inverse of zero: skip the ALU, saturate and flag it.
                     res_d   = {opa_s[W-1], MAG_ONES};
                     err_d   = 1'b1;
                     state_d = S_WB;
                  end else begin
                     alu_r_d       = {1'b0, opa_s[W-2:0]};
                     alu_s_d       = opa_s;
                     alu_f_d       = 1'b1;
                     alu_e_d       = 1'b1;
                     alu_inv_rst_d = 1'b1;
                  end
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
         S_WAIT: begin
            if (op_q != OP_INV) begin
               res_d   = alu_result;
               state_d = S_WB;
            end else if (alu_cont && !alu_inv_rst_q) begin
               // cont is only trusted once the start pulse has dropped.
               res_d   = alu_result;
               state_d = S_WB;
            end else if (timer_q == TW'(INV_TIMEOUT - 1)) begin
               res_d   = {a_sign_q, MAG_ONES};
               err_d   = 1'b1;
               state_d = S_WB;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Writeback has priority over a host load to the same address.
      for (int i = 0; i < NREG; i++) begin
         if (wb_en_s && (dst_q == AW'(i))) begin
            regfile_d[i] = res_q;
         end else if (ld_en && (ld_addr == AW'(i))) begin
            regfile_d[i] = ld_data;
         end else begin
            regfile_d[i] = regfile_q[i];
         end
      end
   end

   // State, operand, control and register-file flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         op_q          <= 2'b00;
         dst_q         <= {AW{1'b0}};
         a_q           <= {AW{1'b0}};
         b_q           <= {AW{1'b0}};
         res_q         <= {W{1'b0}};
         a_sign_q      <= 1'b0;
         timer_q       <= {TW{1'b0}};
         alu_r_q       <= {W{1'b0}};
         alu_s_q       <= {W{1'b0}};
         alu_f_q       <= 1'b0;
         alu_e_q       <= 1'b0;
         alu_inv_rst_q <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regfile_q[i] <= {W{1'b0}};
         end
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         dst_q         <= dst_d;
         a_q           <= a_d;
         b_q           <= b_d;
         res_q         <= res_d;
         a_sign_q      <= a_sign_d;
         timer_q       <= timer_d;
         alu_r_q       <= alu_r_d;
         alu_s_q       <= alu_s_d;
         alu_f_q       <= alu_f_d;
         alu_e_q       <= alu_e_d;
         alu_inv_rst_q <= alu_inv_rst_d;
         done_q        <= done_d;
         err_q         <= err_d;
         for (int i = 0; i < NREG; i++) begin
            regfile_q[i] <= regfile_d[i];
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Self-checking bench for alu_op_sequencer. A behavioural S9.14 ALU answers
//   the sequencer; expected writebacks are pushed to a scoreboard queue when a
//   command is driven and popped when done is seen.
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_dst, cmd_a, cmd_b;
   logic        ld_en;
   logic [3:0]  ld_addr;
   logic [23:0] ld_data;
   logic [3:0]  rd_addr;
   logic [23:0] rd_data;
   logic [23:0] alu_r, alu_s;
   logic        alu_ctl_f, alu_ctl_e, alu_inv_rst;
   logic [23:0] alu_result;
   logic        alu_cont;
   logic        done, err;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .alu_r(alu_r), .alu_s(alu_s), .alu_ctl_f(alu_ctl_f), .alu_ctl_e(alu_ctl_e),
      .alu_inv_rst(alu_inv_rst), .alu_result(alu_result), .alu_cont(alu_cont),
      .done(done), .err(err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- S9.14 sign-magnitude arithmetic model ----------------
   function automatic longint sm2i(input logic [23:0] x);
      longint m;
      m = longint'(x[22:0]);
      return x[23] ? -m : m;
   endfunction

   function automatic logic [23:0] i2sm(input longint v);
      logic   sg;
      longint m;
      sg = (v < 0);
      m  = sg ? -v : v;
      if (m > 64'sh7FFFFF) m = 64'sh7FFFFF;
      return {sg, m[22:0]};
   endfunction

   function automatic logic [23:0] sm_add(input logic [23:0] a, input logic [23:0] b);
      return i2sm(sm2i(a) + sm2i(b));
   endfunction

   function automatic logic [23:0] sm_mul(input logic [23:0] a, input logic [23:0] b);
      longint m;
      m = (longint'(a[22:0]) * longint'(b[22:0])) >>> 14;
      if (m > 64'sh7FFFFF) m = 64'sh7FFFFF;
      return (m == 0) ? 24'h000000 : {a[23] ^ b[23], m[22:0]};
   endfunction

   // ---------------- ALU model ----------------
   logic        inv_active = 1'b0;   // current command is an INV
   logic        inv_stale  = 1'b0;   // cont level presented before the start pulse
   logic        inv_never  = 1'b0;   // inverse unit never answers
   int          inv_hold   = 24;     // cycles after the pulse before cont rises
   logic [23:0] inv_value  = 24'h0;
   logic        inv_armed  = 1'b0;
   logic        inv_ok     = 1'b0;
   int          inv_cnt    = 0;
   int          pulses     = 0;

   assign alu_result = inv_active ? (inv_ok ? inv_value : 24'h5A5A5A)
                                  : (alu_ctl_f ? sm_mul(alu_r, alu_s) : sm_add(alu_r, alu_s));

   always @(negedge clk) begin
      if (alu_inv_rst) begin
         pulses++;
         inv_cnt   = 0;
         inv_armed = 1'b1;
      end else if (inv_active && inv_armed) begin
         inv_cnt++;
         alu_cont = !inv_never && (inv_cnt >= inv_hold);
         inv_ok   = alu_cont;
      end else begin
         alu_cont = inv_stale && inv_active;
         inv_ok   = 1'b0;
         if (!inv_active) inv_armed = 1'b0;
      end
   end

   // ---------------- scoreboard and register mirror ----------------
   typedef struct {
      logic [3:0]  dst;
      logic [23:0] val;
   } sb_t;
   sb_t         sb[$];
   logic [23:0] mirror [16];

   logic [23:0] issue_r, issue_s;
   logic        issue_f, issue_e;
   logic        ready_mid;

   task automatic ld_reg(input logic [3:0] a, input logic [23:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk);
      #1 ld_en = 1'b0;
      mirror[a] = d;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] a,
                          input logic [3:0] b, input int exp_lat, input int ld_off,
                          input logic [3:0] ld_a, input logic [23:0] ld_d, input string tag);
      logic [23:0] av, bv, e;
      sb_t         it;
      int          lat;
      logic        got;
      av = mirror[a];
      bv = mirror[b];
      case (op)
         2'b00:   e = sm_add(av, bv);
         2'b01:   e = i2sm(sm2i(av) - sm2i(bv));
         2'b10:   e = sm_mul(av, bv);
         default: e = ((av[22:0] == 23'h0) || inv_never) ? {av[23], 23'h7FFFFF} : inv_value;
      endcase
      sb.push_back('{dst: dst, val: e});
      @(negedge clk);
      check_val({tag, "_ready"}, cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_a = a; cmd_b = b;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      ready_mid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
         end else begin
            if (lat <= 1) ready_mid = ready_mid | cmd_ready;
            if (lat == 1) begin
               issue_r = alu_r; issue_s = alu_s; issue_f = alu_ctl_f; issue_e = alu_ctl_e;
            end
            ld_en = (ld_off > 0) && (lat + 1 == ld_off);
            ld_addr = ld_a; ld_data = ld_d;
            @(posedge clk);
            #1 ld_en = 1'b0;
            lat++;
         end
      end
      it = sb.pop_front();
      if (!got) begin
         check_val({tag, "_done_timeout"}, 32'd0, 32'd1);
      end else begin
         if (exp_lat >= 0) check_val({tag, "_latency"}, lat, exp_lat);
         if (ld_off > 0 && ld_a != it.dst) mirror[ld_a] = ld_d;
         mirror[it.dst] = it.val;
         rd_addr = it.dst;
         #1 check_val({tag, "_wb"}, rd_data, it.val);
         if (ld_off > 0 && ld_a != it.dst) begin
            rd_addr = ld_a;
            #1 check_val({tag, "_ld"}, rd_data, ld_d);
         end
         @(negedge clk);
         check_val({tag, "_done_pulse"}, done, 1'b0);
      end
   endtask

   int p0;
   int acc[$];
   int n_done;

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dst = 4'h0; cmd_a = 4'h0; cmd_b = 4'h0;
      ld_en = 1'b0; ld_addr = 4'h0; ld_data = 24'h0; rd_addr = 4'h5;
      for (int i = 0; i < 16; i++) mirror[i] = 24'h0;
      #3;
      check_val("rst_ready", cmd_ready, 1'b1);
      check_val("rst_done", done, 1'b0);
      check_val("rst_err", err, 1'b0);
      check_val("rst_alu_r", alu_r, 24'h0);
      check_val("rst_inv_rst", alu_inv_rst, 1'b0);
      check_val("rst_rd", rd_data, 24'h0);
      @(negedge clk);
      rst = 1'b0;

      // 1: ADD r3 = r1 + r2
      ld_reg(4'd1, 24'h00C000);
      ld_reg(4'd2, 24'h008000);
      run_cmd(2'b00, 4'd3, 4'd1, 4'd2, 3, 0, 4'd0, 24'h0, "add");
      check_val("add_alu_r", issue_r, 24'h00C000);
      check_val("add_alu_s", issue_s, 24'h008000);
      check_val("add_fe", {issue_f, issue_e}, 2'b00);
      check_val("add_r3", mirror[3], 24'h014000);

      // 2: SUB r4 = r2 - r1
      run_cmd(2'b01, 4'd4, 4'd2, 4'd1, 3, 0, 4'd0, 24'h0, "sub");
      check_val("sub_alu_s", issue_s, 24'h80C000);
      check_val("sub_r4", mirror[4], 24'h804000);

      // 3: MUL r5 = r1 * r2
      run_cmd(2'b10, 4'd5, 4'd1, 4'd2, 3, 0, 4'd0, 24'h0, "mul");
      check_val("mul_fe", {issue_f, issue_e}, 2'b10);
      check_val("mul_ready_low", ready_mid, 1'b0);
      check_val("mul_r5", mirror[5], 24'h018000);

      // Writeback beats a same-edge load to the same register
      run_cmd(2'b00, 4'd7, 4'd1, 4'd2, 3, 3, 4'd7, 24'h111111, "wbwin");
      // dst == a, with a load to another register on the writeback edge
      run_cmd(2'b00, 4'd1, 4'd1, 4'd1, 3, 3, 4'd9, 24'h000123, "dsta");
      // A load on the issue edge is not seen by the operand read
      run_cmd(2'b00, 4'd10, 4'd11, 4'd2, 3, 1, 4'd11, 24'h004000, "ldiss");

      // 4: INV r6 = 1/r2, unit answers after a delay; stale cont must be ignored
      inv_active = 1'b1; inv_stale = 1'b1; inv_never = 1'b0; inv_hold = 24; inv_value = 24'h002000;
      p0 = pulses;
      run_cmd(2'b11, 4'd6, 4'd2, 4'd0, -1, 0, 4'd0, 24'h0, "inv");
      check_val("inv_pulses", pulses - p0, 1);
      check_val("inv_alu_r", issue_r, 24'h008000);
      check_val("inv_alu_s", issue_s, 24'h008000);
      check_val("inv_fe", {issue_f, issue_e}, 2'b11);
      check_val("inv_err", err, 1'b0);

      // 5: INV timeout, then INV of negative zero
      inv_stale = 1'b0; inv_never = 1'b1;
      p0 = pulses;
      run_cmd(2'b11, 4'd6, 4'd2, 4'd0, 34, 0, 4'd0, 24'h0, "invto");
      check_val("invto_pulses", pulses - p0, 1);
      check_val("invto_r6", mirror[6], 24'h7FFFFF);
      check_val("invto_err", err, 1'b1);
      inv_never = 1'b0;
      ld_reg(4'd0, 24'h800000);
      p0 = pulses;
      run_cmd(2'b11, 4'd12, 4'd0, 4'd0, 2, 0, 4'd0, 24'h0, "inv0");
      check_val("inv0_pulses", pulses - p0, 0);
      check_val("inv0_alu_r_held", issue_r, 24'h008000);
      check_val("inv0_r12", mirror[12], 24'hFFFFFF);
      check_val("inv0_err", err, 1'b1);

      // 6: reset in the middle of an INV wait
      inv_never = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_dst = 4'd6; cmd_a = 4'd2; cmd_b = 4'd0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("mrst_done", done, 1'b0);
      check_val("mrst_alu_r", alu_r, 24'h0);
      check_val("mrst_alu_s", alu_s, 24'h0);
      check_val("mrst_err", err, 1'b0);
      check_val("mrst_ready", cmd_ready, 1'b1);
      rd_addr = 4'd2;
      #1 check_val("mrst_r2", rd_data, 24'h0);
      @(negedge clk);
      rst = 1'b0;
      inv_active = 1'b0; inv_never = 1'b0;
      sb.delete();
      for (int i = 0; i < 16; i++) mirror[i] = 24'h0;
      repeat (4) @(negedge clk);
      rd_addr = 4'd6;
      #1 check_val("mrst_no_wb", rd_data, 24'h0);

      // Held cmd_valid: accepted once every 3 cycles
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dst = 4'd3; cmd_a = 4'd1; cmd_b = 4'd2;
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (cmd_ready) acc.push_back(c);
         if (done) n_done++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check_val("held_accepts", acc.size(), 4);
      for (int i = 0; i < acc.size() && i < 4; i++) check_val("held_accept_cycle", acc[i], 3 * i);
      check_val("held_dones", n_done, 3);
      repeat (6) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
